// File: rtl/pattern_player_mc.sv
// Multi-lane pattern player: replays a DW-bit pattern from LUTRAM onto IO lanes
// at a programmable rate after a start delay, with loop/one-shot/repeat-N modes.
module pattern_player_mc #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_trig,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [15:0]   rep_num,
    input  logic [AW:0]   len,
    input  logic [31:0]   rate_div,
    input  logic [31:0]   phase_off,
    input  logic [DW-1:0] lane_en,
    input  logic [DW-1:0] idle_val,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] io_out,
    output logic          playing,
    output logic          done,
    output logic [15:0]   pass_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [2**AW];

    logic [1:0]    state;
    logic [AW-1:0] ptr;
    logic [31:0]   div_cnt;
    logic [31:0]   phs_cnt;
    logic          end_pass;
    logic          cfg_valid;

    logic [1:0]    mode_l;
    logic [15:0]   rep_l;
    logic [AW:0]   len_l;
    logic [31:0]   rate_l;
    logic [DW-1:0] lane_l;
    logic [DW-1:0] idle_l;

    logic          start_ok;
    logic          tick;
    logic          last;
    logic          finish;
    logic [15:0]   rep_tgt;
    logic [15:0]   pass_inc;
    logic [AW:0]   len_clamp;
    logic [DW-1:0] shaped;
    logic [DW-1:0] stop_lvl;

    assign playing   = (state != IDLE);
    assign start_ok  = (state == IDLE) && start_trig && !stop && (len != '0);
    assign len_clamp = (len > DEPTH) ? DEPTH : len;
    assign tick      = (state == RUN) && (div_cnt == rate_l);
    assign last      = ({1'b0, ptr} == (len_l - (AW+1)'(1)));
    assign rep_tgt   = (rep_l == 16'd0) ? 16'd1 : rep_l;
    assign pass_inc  = (pass_cnt == 16'hFFFF) ? pass_cnt : pass_cnt + 16'd1;
    assign shaped    = (mem[ptr] & lane_l) | (idle_l & ~lane_l);
    // Before the first start there is no latched idle level, so fall back to the live input.
    assign stop_lvl  = cfg_valid ? idle_l : idle_val;

    // Completion is judged on the tick that would otherwise emit word 0 of the next pass.
    assign finish = end_pass &&
                    ((mode_l == 2'd1) ||
                     ((mode_l == 2'd2) && (({1'b0, pass_cnt} + 17'd1) >= {1'b0, rep_tgt})));

    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE))
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            div_cnt   <= '0;
            phs_cnt   <= '0;
            end_pass  <= 1'b0;
            cfg_valid <= 1'b0;
            io_out    <= '0;
            done      <= 1'b0;
            pass_cnt  <= '0;
            mode_l    <= '0;
            rep_l     <= '0;
            len_l     <= '0;
            rate_l    <= '0;
            lane_l    <= '0;
            idle_l    <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                io_out   <= stop_lvl;
                end_pass <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            mode_l    <= mode;
                            rep_l     <= rep_num;
                            len_l     <= len_clamp;
                            rate_l    <= rate_div;
                            lane_l    <= lane_en;
                            idle_l    <= idle_val;
                            cfg_valid <= 1'b1;
                            ptr       <= '0;
                            div_cnt   <= '0;
                            pass_cnt  <= '0;
                            end_pass  <= 1'b0;
                            phs_cnt   <= phase_off;
                            state     <= (phase_off != 32'd0) ? DELAY : RUN;
                        end
                    end
                    DELAY: begin
                        phs_cnt <= phs_cnt - 32'd1;
                        if (phs_cnt <= 32'd1)
                            state <= RUN;
                    end
                    RUN: begin
                        if (tick) begin
                            div_cnt  <= '0;
                            end_pass <= 1'b0;
                            if (end_pass)
                                pass_cnt <= pass_inc;
                            if (finish) begin
                                io_out <= idle_l;
                                done   <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                io_out <= shaped;
                                if (last) begin
                                    ptr      <= '0;
                                    end_pass <= 1'b1;
                                end else begin
                                    ptr <= ptr + AW'(1);
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_player_mc.sv
// Directed bench for pattern_player_mc: timing, modes, lane masking, stop, clamp, reset.
module tb_pattern_player_mc;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_trig;
    logic          stop;
    logic [1:0]    mode;
    logic [15:0]   rep_num;
    logic [AW:0]   len;
    logic [31:0]   rate_div;
    logic [31:0]   phase_off;
    logic [DW-1:0] lane_en;
    logic [DW-1:0] idle_val;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] io_out;
    logic          playing;
    logic          done;
    logic [15:0]   pass_cnt;

    int n_vec = 0;
    int n_err = 0;

    pattern_player_mc #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_trig(start_trig), .stop(stop),
        .mode(mode), .rep_num(rep_num), .len(len), .rate_div(rate_div),
        .phase_off(phase_off), .lane_en(lane_en), .idle_val(idle_val),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .io_out(io_out), .playing(playing), .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic go();
        start_trig = 1'b1;
        step();
        start_trig = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_trig = 1'b0; stop = 1'b0; mode = 2'd0; rep_num = 16'd0;
        len = '0; rate_div = 32'd0; phase_off = 32'd0; lane_en = 8'hFF; idle_val = 8'h55;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) step();
        chk("rst_io", io_out, 8'h00);
        chk("rst_playing", playing, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass_cnt, 16'd0);
        rst_n = 1'b1;
        step();

        // one-shot, 1 sample per clock
        wr(4'd0, 8'h01); wr(4'd1, 8'h02); wr(4'd2, 8'h03);
        mode = 2'd1; len = 5'd3;
        go();
        chk("t1_playing", playing, 1'b1);
        chk("t1_io_hold", io_out, 8'h00);
        step(); chk("t1_e1", io_out, 8'h01);
        step(); chk("t1_e2", io_out, 8'h02);
        step(); chk("t1_e3", io_out, 8'h03);
        chk("t1_e3_done", done, 1'b0);
        step(); chk("t1_e4_io", io_out, 8'h55);
        chk("t1_e4_done", done, 1'b1);
        chk("t1_e4_pass", pass_cnt, 16'd1);
        chk("t1_e4_playing", playing, 1'b0);
        step(); chk("t1_done_pulse", done, 1'b0);

        // loop mode with divider and start delay
        mode = 2'd0; rate_div = 32'd3; phase_off = 32'd5;
        go();
        for (int e = 1; e <= 33; e++) begin
            step();
            if (e == 8)  chk("t2_pre", io_out, 8'h55);
            if (e == 9)  chk("t2_e9", io_out, 8'h01);
            if (e == 13) chk("t2_e13", io_out, 8'h02);
            if (e == 17) chk("t2_e17", io_out, 8'h03);
            if (e == 20) chk("t2_pass_e20", pass_cnt, 16'd0);
            if (e == 21) begin
                chk("t2_e21", io_out, 8'h01);
                chk("t2_pass_e21", pass_cnt, 16'd1);
            end
            if (e == 33) begin
                chk("t2_pass_e33", pass_cnt, 16'd2);
                chk("t2_playing", playing, 1'b1);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_stop_io", io_out, 8'h55);
        chk("t2_stop_playing", playing, 1'b0);
        chk("t2_stop_done", done, 1'b0);
        chk("t2_stop_pass", pass_cnt, 16'd2);

        // repeat-N
        mode = 2'd2; rep_num = 16'd2; len = 5'd2; rate_div = 32'd0; phase_off = 32'd0;
        go();
        step(); chk("t3_e1", io_out, 8'h01);
        step(); chk("t3_e2", io_out, 8'h02);
        step(); chk("t3_e3", io_out, 8'h01);
        step(); chk("t3_e4", io_out, 8'h02);
        chk("t3_e4_done", done, 1'b0);
        step(); chk("t3_e5_done", done, 1'b1);
        chk("t3_e5_pass", pass_cnt, 16'd2);
        chk("t3_e5_io", io_out, 8'h55);
        rep_num = 16'd0;
        go();
        step(); chk("t3z_e1", io_out, 8'h01);
        step(); chk("t3z_e2", io_out, 8'h02);
        step(); chk("t3z_e3_done", done, 1'b1);
        chk("t3z_e3_pass", pass_cnt, 16'd1);

        // lane masking
        wr(4'd0, 8'hFF);
        mode = 2'd1; len = 5'd1; rate_div = 32'd1; lane_en = 8'h0F; idle_val = 8'hA0;
        go();
        step(); chk("t4_e1", io_out, 8'h55);
        step(); chk("t4_e2", io_out, 8'hAF);
        step(); chk("t4_e3", io_out, 8'hAF);
        step(); chk("t4_e4_io", io_out, 8'hA0);
        chk("t4_e4_done", done, 1'b1);

        // stop vs start, stop mid-run, write while playing
        wr(4'd0, 8'h01);
        idle_val = 8'h33; stop = 1'b1; start_trig = 1'b1;
        step();
        stop = 1'b0; start_trig = 1'b0;
        chk("t5_nostart", playing, 1'b0);
        chk("t5_nostart_io", io_out, 8'hA0);
        mode = 2'd0; len = 5'd3; rate_div = 32'd0; lane_en = 8'hFF; idle_val = 8'h55;
        go();
        step(); chk("t5_e1", io_out, 8'h01);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hEE;
        step(); wr_en = 1'b0;
        chk("t5_e2", io_out, 8'h02);
        step(); chk("t5_e3", io_out, 8'h03);
        stop = 1'b1;
        step(); stop = 1'b0;
        chk("t5_stop_io", io_out, 8'h55);
        chk("t5_stop_playing", playing, 1'b0);
        chk("t5_stop_done", done, 1'b0);
        chk("t5_stop_pass", pass_cnt, 16'd0);
        mode = 2'd1;
        go();
        step(); chk("t5_mem_w0", io_out, 8'h01);
        step(); chk("t5_mem_kept", io_out, 8'h02);
        repeat (3) step();

        // len=0 ignored, length clamp
        len = '0;
        go();
        chk("t6_len0", playing, 1'b0);
        for (int i = 0; i < 16; i++) wr(AW'(i), 8'(8'h10 + i));
        len = 5'd21; mode = 2'd1;
        go();
        for (int e = 1; e <= 17; e++) begin
            step();
            if (e == 1)  chk("t6_e1", io_out, 8'h10);
            if (e == 16) chk("t6_e16", io_out, 8'h1F);
            if (e == 17) begin
                chk("t6_e17_done", done, 1'b1);
                chk("t6_e17_io", io_out, 8'h55);
                chk("t6_e17_pass", pass_cnt, 16'd1);
            end
        end

        // async reset while in DELAY
        mode = 2'd0; phase_off = 32'd10;
        go();
        repeat (3) step();
        chk("t6_delay_playing", playing, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_io", io_out, 8'h00);
        chk("t6_rst_playing", playing, 1'b0);
        chk("t6_rst_pass", pass_cnt, 16'd0);
        #2;
        rst_n = 1'b1;
        step();
        chk("t6_post_rst_idle", playing, 1'b0);
        phase_off = 32'd0; len = 5'd1; mode = 2'd1;
        go();
        step(); chk("t6_mem_after_rst", io_out, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
